seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, width PAT_W: target sequence, MSB received first.
REQ-003 Parameter OVERLAP, default 1: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  qualifies din; when low the bit is ignored.
REQ-009 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-010 y  output  1  Moore match flag; high while the FSM is in the match state.
REQ-011 match_cnt  output  CNT_W  saturating count of matches detected.
REQ-012 progress  output  $clog2(PAT_W+1)  current state index 0..PAT_W (bits of pattern matched).

Function
REQ-013 FSM SHALL have PAT_W+1 states S0..S{PAT_W}; Sk means the last k accepted bits equal the first k pattern bits; S{PAT_W} is the match state.
REQ-014 From Sk with k<PAT_W and valid bit b: if b equals pattern bit k (MSB = bit 0), next is S{k+1}; otherwise next is the longest proper prefix of the pattern that is a suffix of (matched prefix followed by b) (KMP failure transition).
REQ-015 From S{PAT_W} with OVERLAP=1: next state SHALL be computed as in REQ-014 starting from S{f}, where f is the longest proper border of PATTERN.
REQ-016 From S{PAT_W} with OVERLAP=0: next state SHALL be computed as in REQ-014 starting from S0.
REQ-017 din_valid low: state, y and progress SHALL hold their values; y stays high if the FSM is already in S{PAT_W}.
REQ-018 y SHALL be a decode of the registered state only; no combinational path from din or din_valid to y.
REQ-019 Latency: y rises in the cycle after the clock edge that accepts the final pattern bit.
REQ-020 match_cnt SHALL increment by 1 on each transition into S{PAT_W}, including a self-transition S{PAT_W}->S{PAT_W} on a valid bit.
REQ-021 match_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-022 clr_cnt SHALL have priority over increment: a simultaneous clear and match leaves match_cnt = 0; clr_cnt SHALL NOT affect the FSM.
REQ-023 All transition targets SHALL be resolved at elaboration time from PATTERN; no runtime pattern storage.

Reset
REQ-024 rst high at a clock edge SHALL force state S0, y=0, progress=0 and match_cnt=0, overriding din_valid and clr_cnt.
REQ-025 Reset asserted mid-pattern SHALL discard partial progress; detection restarts from S0 on the first valid bit after rst deasserts.

Structure
REQ-026 Package seq_det_pkg SHALL hold an elaboration-time function that computes the next state from (state, bit, PATTERN, PAT_W) and a border function used for REQ-015.
REQ-027 The saturating counter with clear SHALL be a separate sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q).
REQ-028 The FSM SHALL use one registered state vector and one combinational next-state block.

Verification
REQ-029 Defaults, OVERLAP=1, valid bits 1,0,1,1,0,1,1 -> y high one cycle after bit 4 and one cycle after bit 7; match_cnt = 2.
REQ-030 OVERLAP=0, same stream -> y high only after bit 4; match_cnt = 1; progress = 1 after bit 7.
REQ-031 PAT_W=3, PATTERN=3'b111, OVERLAP=1, five valid 1s -> y high after bits 3, 4 and 5 (S3 self-loop); match_cnt = 3.
REQ-032 Stream 1,0,1 with din_valid low for 3 cycles, then valid 1 -> progress holds at 3 during the gap; y rises after the final valid bit.
REQ-033 CNT_W=2, six overlapping matches -> match_cnt = 3 (saturated); clr_cnt pulsed in the same cycle as a match -> match_cnt = 0.
REQ-034 rst asserted after bits 1,0,1 -> progress = 0 the next cycle; then bit 1 -> progress = 1 and no false match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module  : seq_det_pkg
// Brief   : Elaboration-time helpers for the parameterised sequence detector:
//           KMP next-state and border computation, plus counter op encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int MAX_PAT_W = 16;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_CLR  = 2'd2
    } cnt_op_e;

    // Pattern bit i in reception order: i = 0 is the MSB of the pattern word.
    function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat,
                                     input int w, input int i);
        logic [MAX_PAT_W-1:0] t;
        t = pat >> (w - 1 - i);
        return t[0];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border(input logic [MAX_PAT_W-1:0] pat, input int w);
        int  res;
        logic ok;
        res = 0;
        for (int f = 1; f < w; f++) begin
            ok = 1'b1;
            for (int i = 0; i < f; i++) begin
                if (pat_bit(pat, w, i) != pat_bit(pat, w, w - f + i))
                    ok = 1'b0;
            end
            if (ok)
                res = f;
        end
        return res;
    endfunction

    // From state k (< w), accepting bit b: length of the longest pattern
    // prefix that is a suffix of (first k pattern bits, then b).
    function automatic int next_state(input int k, input logic b,
                                      input logic [MAX_PAT_W-1:0] pat,
                                      input int w);
        int   res;
        int   idx;
        logic ok;
        logic sbit;
        res = 0;
        for (int j = 1; j <= k + 1; j++) begin
            if (j <= w) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    idx  = k + 1 - j + i;
                    sbit = (idx < k) ? pat_bit(pat, w, idx) : b;
                    if (sbit != pat_bit(pat, w, i))
                        ok = 1'b0;
                end
                if (ok)
                    res = j;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear beats inc).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    cnt_op_e op;

    always_comb begin
        op = CNT_HOLD;
        if (clr)
            op = CNT_CLR;
        else if (inc)
            op = CNT_INC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (op)
                CNT_CLR: q <= '0;
                CNT_INC: if (q != {W{1'b1}}) q <= q + 1'b1;
                default: q <= q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
// Module  : seq_detect_param
// Brief   : Parameterised serial pattern detector (KMP Moore FSM) with a
//           saturating match counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       clr_cnt,
    output logic                       y,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_W+1)-1:0] progress
);

    localparam int                   SW       = $clog2(PAT_W + 1);
    localparam int                   N_ENC    = 1 << SW;
    localparam logic [MAX_PAT_W-1:0] PAT_EXT  = MAX_PAT_W'(PATTERN);
    localparam int                   BORDER   = border(PAT_EXT, PAT_W);
    localparam logic [SW-1:0]        MATCH_ST = SW'(PAT_W);

    logic [SW-1:0] nxt_on0 [N_ENC];
    logic [SW-1:0] nxt_on1 [N_ENC];
    logic [SW-1:0] state;
    logic [SW-1:0] state_next;
    logic          enter_match;

    // Transition table built at elaboration; unused encodings fall back to S0.
    for (genvar k = 0; k < N_ENC; k++) begin : g_state
        if (k <= PAT_W) begin : g_live
            localparam int SRC = (k == PAT_W) ? ((OVERLAP != 0) ? BORDER : 0) : k;
            localparam int N0  = next_state(SRC, 1'b0, PAT_EXT, PAT_W);
            localparam int N1  = next_state(SRC, 1'b1, PAT_EXT, PAT_W);
            assign nxt_on0[k] = SW'(N0);
            assign nxt_on1[k] = SW'(N1);
        end else begin : g_unused
            assign nxt_on0[k] = '0;
            assign nxt_on1[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= '0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (din_valid)
            state_next = din ? nxt_on1[state] : nxt_on0[state];
    end

    // Counts every valid-bit entry into the match state, self-loop included.
    assign enter_match = din_valid && (state_next == MATCH_ST);

    assign y        = (state == MATCH_ST);
    assign progress = state;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (enter_match),
        .q   (match_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
// Module  : tb_seq_detect_param
// Brief   : Self-checking bench: four detector configurations against a
//           suffix/prefix reference model, directed and random stimulus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic clr_cnt = 1'b0;

    logic       y0, y1, y2, y3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic [2:0] prog0, prog1, prog3;
    logic [1:0] prog2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .y(y0), .match_cnt(cnt0), .progress(prog0));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .y(y1), .match_cnt(cnt1), .progress(prog1));
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .y(y2), .match_cnt(cnt2), .progress(prog2));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) d3 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .y(y3), .match_cnt(cnt3), .progress(prog3));

    // Reference model: the state is the longest suffix of the accepted history
    // (history restarts after a match when not overlapping) that is a pattern prefix.
    int          cfg_pw  [4] = '{4, 4, 3, 4};
    int          cfg_pat [4] = '{11, 11, 7, 11};
    int          cfg_ov  [4] = '{1, 0, 1, 1};
    int          cfg_cw  [4] = '{8, 8, 8, 2};
    logic [31:0] hist    [4];
    int          hlen    [4];
    int          mstate  [4];
    longint      mcnt    [4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int act_y(input int i);
        case (i)
            0: return int'(y0);
            1: return int'(y1);
            2: return int'(y2);
            default: return int'(y3);
        endcase
    endfunction

    function automatic int act_cnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    function automatic int act_prog(input int i);
        case (i)
            0: return int'(prog0);
            1: return int'(prog1);
            2: return int'(prog2);
            default: return int'(prog3);
        endcase
    endfunction

    function automatic int longest_prefix(input logic [31:0] h, input int len,
                                          input int pat, input int pw);
        int lim;
        lim = (len < pw) ? len : pw;
        for (int j = lim; j > 0; j--) begin
            if ((h & ((32'd1 << j) - 1)) == (32'(pat) >> (pw - j)))
                return j;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                hist[i] = '0; hlen[i] = 0; mstate[i] = 0; mcnt[i] = 0;
            end else begin
                if (din_valid) begin
                    hist[i] = (hist[i] << 1) | 32'(din);
                    if (hlen[i] < 32) hlen[i]++;
                    mstate[i] = longest_prefix(hist[i], hlen[i], cfg_pat[i], cfg_pw[i]);
                    if (mstate[i] == cfg_pw[i] && cfg_ov[i] == 0)
                        hlen[i] = 0;
                end
                if (clr_cnt)
                    mcnt[i] = 0;
                else if (din_valid && mstate[i] == cfg_pw[i] &&
                         mcnt[i] < ((64'd1 << cfg_cw[i]) - 1))
                    mcnt[i]++;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d.y", i), act_y(i), (mstate[i] == cfg_pw[i]) ? 1 : 0);
            check($sformatf("d%0d.match_cnt", i), act_cnt(i), int'(mcnt[i]));
            check($sformatf("d%0d.progress", i), act_prog(i), mstate[i]);
        end
    end

    task automatic drive(input logic r, input logic v, input logic b, input logic c);
        @(negedge clk);
        rst = r; din_valid = v; din = b; clr_cnt = c;
        @(posedge clk);
        #2;
    endtask

    task automatic bit_in(input logic b);
        drive(1'b0, 1'b1, b, 1'b0);
    endtask

    initial begin
        logic [6:0] s7;
        logic [2:0] tail;

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset y", int'(y0), 0);
        check("reset cnt", int'(cnt0), 0);
        check("reset progress", int'(prog0), 0);

        // 1,0,1,1,0,1,1 : overlap matches after bits 4 and 7, non-overlap only after 4
        s7 = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s7[i]);
            if (i == 4) check("seq1 no early y", int'(y0), 0);
            if (i == 3) begin
                check("seq1 ov y bit4", int'(y0), 1);
                check("seq1 nov y bit4", int'(y1), 1);
            end
            if (i == 0) begin
                check("seq1 ov y bit7", int'(y0), 1);
                check("seq1 ov cnt", int'(cnt0), 2);
                check("seq1 nov y bit7", int'(y1), 0);
                check("seq1 nov cnt", int'(cnt1), 1);
                check("seq1 nov progress", int'(prog1), 1);
            end
        end

        // five 1s into the 111 detector: S3 self-loop
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            bit_in(1'b1);
            if (i == 2) check("ones y bit2", int'(y2), 0);
            if (i >= 3) check($sformatf("ones y bit%0d", i), int'(y2), 1);
        end
        check("ones cnt", int'(cnt2), 3);

        // invalid gap holds progress, then completes the pattern
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
            check("gap progress", int'(prog0), 3);
            check("gap y", int'(y0), 0);
        end
        bit_in(1'b1);
        check("gap final y", int'(y0), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap y holds", int'(y0), 1);

        // six overlapping matches saturate the 2-bit counter, then clear wins
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        tail = 3'b011;
        for (int m = 0; m < 5; m++)
            for (int i = 2; i >= 0; i--) bit_in(tail[i]);
        check("sat cnt3", int'(cnt3), 3);
        check("sat cnt0", int'(cnt0), 6);
        bit_in(1'b0); bit_in(1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("clr y", int'(y3), 1);
        check("clr cnt3", int'(cnt3), 0);
        check("clr cnt0", int'(cnt0), 0);

        // reset mid-pattern discards progress, overriding valid and clear
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst progress", int'(prog0), 0);
        bit_in(1'b1);
        check("post-rst progress", int'(prog0), 1);
        check("post-rst y", int'(y0), 0);

        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)),
                  ($urandom_range(39) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
